// File: rtl/serial_subtractor_pkg.sv
// Shared types and helpers for the bit-serial subtractor.
package serial_subtractor_pkg;

   // Controller states: wait for a request, shift one bit per cycle, present the result.
   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StShift = 2'd1,
      StDone  = 2'd2
   } state_e;

   // Bit-counter width for a given operand width; counts 0 .. width-1.
   function automatic int unsigned cnt_width(input int unsigned width);
      return (width > 1) ? $clog2(width) : 1;
   endfunction

endpackage

// File: rtl/full_subtractor.sv
// Single-bit full subtractor cell: D = A - B - Bin with borrow-out.
module full_subtractor (
   input  logic i_a,
   input  logic i_b,
   input  logic i_bin,
   output logic o_d,
   output logic o_bout
);

   assign o_d    = i_a ^ i_b ^ i_bin;
   assign o_bout = (~i_a & i_b) | (~(i_a ^ i_b) & i_bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor: Difference = A - B - Bin, one bit per clock, LSB first.
// Optional signed-overflow output enabled by defining SERIAL_SUBTRACTOR_OVERFLOW_EN.
module serial_subtractor
   import serial_subtractor_pkg::*;
#(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] A_in,
   input  logic [WIDTH-1:0] B_in,
   input  logic             Bin_in,
   output logic             ready,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] Difference_out,
`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
   output logic             Overflow_out,
`endif
   output logic             Borrow_out
);

   localparam int unsigned CntW = cnt_width(WIDTH);

   state_e           r_state;
   state_e           w_state_next;
   logic [WIDTH-1:0] r_op_a;
   logic [WIDTH-1:0] r_op_b;
   logic [WIDTH-1:0] r_result;
   logic [WIDTH-1:0] r_diff;
   logic             r_borrow;
   logic             r_borrow_out;
   logic [CntW-1:0]  r_count;
   logic             w_d;
   logic             w_bo;
   logic             w_last;
   logic [WIDTH-1:0] w_result_next;

`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
   logic [1:0]       r_msb;       // {A MSB, B MSB} captured at start
   logic             r_overflow;
   assign Overflow_out = r_overflow;
`endif

   full_subtractor u_cell (
      .i_a    (r_op_a[0]),
      .i_b    (r_op_b[0]),
      .i_bin  (r_borrow),
      .o_d    (w_d),
      .o_bout (w_bo)
   );

   assign w_last        = (r_count == CntW'(WIDTH - 1));
   // New difference bit enters at the MSB; after WIDTH shifts bit 0 lands at the LSB.
   assign w_result_next = (r_result >> 1) | (WIDTH'(w_d) << (WIDTH - 1));

   assign Difference_out = r_diff;
   assign Borrow_out     = r_borrow_out;

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= StIdle;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Next-state and status outputs.
   always_comb begin
      w_state_next = r_state;
      ready        = 1'b0;
      busy         = 1'b0;
      done         = 1'b0;
      case (r_state)
         StIdle: begin
            ready = 1'b1;
            if (start) w_state_next = StShift;
         end
         StShift: begin
            busy = 1'b1;
            if (w_last) w_state_next = StDone;
         end
         StDone: begin
            done         = 1'b1;
            w_state_next = StIdle;
         end
         default: w_state_next = StIdle;
      endcase
   end

   // Operand capture, bit shifting and result latching.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_op_a       <= '0;
         r_op_b       <= '0;
         r_result     <= '0;
         r_diff       <= '0;
         r_borrow     <= 1'b0;
         r_borrow_out <= 1'b0;
         r_count      <= '0;
`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
         r_msb        <= 2'b00;
         r_overflow   <= 1'b0;
`endif
      end else begin
         case (r_state)
            StIdle: begin
               if (start) begin
                  r_op_a   <= A_in;
                  r_op_b   <= B_in;
                  r_borrow <= Bin_in;
                  r_count  <= '0;
`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
                  r_msb    <= {A_in[WIDTH-1], B_in[WIDTH-1]};
`endif
               end
            end
            StShift: begin
               r_result <= w_result_next;
               r_op_a   <= r_op_a >> 1;
               r_op_b   <= r_op_b >> 1;
               r_borrow <= w_bo;
               r_count  <= r_count + 1'b1;
               // Publish on the final bit so outputs are valid while done is high.
               if (w_last) begin
                  r_diff       <= w_result_next;
                  r_borrow_out <= w_bo;
`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
                  r_overflow   <= (r_msb[1] ^ r_msb[0]) & (r_msb[1] ^ w_d);
`endif
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor (WIDTH=8) against an arithmetic reference model.
module tb_serial_subtractor;

   localparam int unsigned W = 8;

   logic         clk = 1'b0;
   logic         rst;
   logic         start;
   logic [W-1:0] a_in;
   logic [W-1:0] b_in;
   logic         bin_in;
   logic         ready;
   logic         busy;
   logic         done;
   logic [W-1:0] diff;
   logic         borrow;
`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
   logic         ovf;
`endif

   int unsigned n_checks = 0;
   int unsigned n_errors = 0;

   serial_subtractor #(.WIDTH(W)) dut (
      .clk            (clk),
      .rst            (rst),
      .start          (start),
      .A_in           (a_in),
      .B_in           (b_in),
      .Bin_in         (bin_in),
      .ready          (ready),
      .busy           (busy),
      .done           (done),
      .Difference_out (diff),
`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
      .Overflow_out   (ovf),
`endif
      .Borrow_out     (borrow)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Reference: {overflow, borrow, difference} from plain integer arithmetic.
   function automatic logic [9:0] model(input logic [7:0] a, input logic [7:0] b, input logic bin);
      int ua, ub, ib, sa, sb, r;
      logic [7:0] d;
      logic bo, ov;
      ua = int'(a);
      ub = int'(b);
      ib = bin ? 1 : 0;
      d  = 8'((ua - ub - ib) & 255);
      bo = (ua < ub + ib);
      sa = $signed(a);
      sb = $signed(b);
      r  = sa - sb - ib;
      ov = (r < -128) || (r > 127);
      return {ov, bo, d};
   endfunction

   task automatic wait_ready();
      int n = 0;
      while (!ready && n < 40) begin
         @(negedge clk);
         n++;
      end
      check_eq("ready_wait", 32'(ready), 32'd1);
   endtask

   task automatic start_op(input logic [7:0] a, input logic [7:0] b, input logic bin);
      start  = 1'b1;
      a_in   = a;
      b_in   = b;
      bin_in = bin;
      @(negedge clk);
      start  = 1'b0;
   endtask

   task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic bin);
      int lat, bc;
      logic [7:0] d0;
      logic b0;
      logic changed;
      logic [9:0] exp;
      string op;
      op = $sformatf("%02h-%02h-%0d", a, b, bin);
      exp = model(a, b, bin);
      wait_ready();
      d0 = diff;
      b0 = borrow;
      changed = 1'b0;
      start_op(a, b, bin);
      lat = 1;
      bc  = 0;
      while (!done && lat < 40) begin
         if (busy) bc++;
         if (diff !== d0 || borrow !== b0) changed = 1'b1;
         @(negedge clk);
         lat++;
      end
      check_eq({"latency ", op}, 32'(lat), 32'd9);
      check_eq({"busy_cycles ", op}, 32'(bc), 32'd8);
      check_eq({"held ", op}, 32'(changed), 32'd0);
      check_eq({"diff ", op}, 32'(diff), 32'(exp[7:0]));
      check_eq({"borrow ", op}, 32'(borrow), 32'(exp[8]));
`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
      check_eq({"ovf ", op}, 32'(ovf), 32'(exp[9]));
`endif
      @(negedge clk);
      check_eq({"done_pulse ", op}, 32'(done), 32'd0);
      check_eq({"diff_hold ", op}, 32'(diff), 32'(exp[7:0]));
   endtask

   initial begin
      int dones;
      int c1, c2;
      logic [7:0] dcap [2];
      logic bcap [2];
      logic ocap [2];
      logic [7:0] ca [5];
      logic [9:0] e1, e2;

      rst    = 1'b1;
      start  = 1'b0;
      a_in   = '0;
      b_in   = '0;
      bin_in = 1'b0;
      repeat (2) @(negedge clk);
      check_eq("rst_ready", 32'(ready), 32'd1);
      check_eq("rst_busy", 32'(busy), 32'd0);
      check_eq("rst_done", 32'(done), 32'd0);
      check_eq("rst_diff", 32'(diff), 32'd0);
      check_eq("rst_borrow", 32'(borrow), 32'd0);
      rst = 1'b0;
      @(negedge clk);

      // Directed cases.
      run_op(8'h35, 8'h12, 1'b0);
      run_op(8'h00, 8'h01, 1'b0);
      run_op(8'h10, 8'h0F, 1'b1);

      // Start pulsed during SHIFT must be ignored.
      wait_ready();
      start_op(8'hAA, 8'h55, 1'b0);
      @(negedge clk);
      @(negedge clk);
      start_op(8'h01, 8'h01, 1'b0);
      dones = 0;
      dcap[0] = '0;
      bcap[0] = 1'b1;
      for (int i = 0; i < 20; i++) begin
         if (done) begin
            dones++;
            dcap[0] = diff;
            bcap[0] = borrow;
         end
         @(negedge clk);
      end
      check_eq("busy_prot_dones", 32'(dones), 32'd1);
      check_eq("busy_prot_diff", 32'(dcap[0]), 32'h55);
      check_eq("busy_prot_borrow", 32'(bcap[0]), 32'd0);
      check_eq("busy_prot_idle", 32'(busy), 32'd0);

      // Reset on the 4th SHIFT cycle aborts without a done pulse.
      wait_ready();
      start_op(8'hFF, 8'h01, 1'b0);
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check_eq("abort_ready", 32'(ready), 32'd1);
      check_eq("abort_busy", 32'(busy), 32'd0);
      check_eq("abort_diff", 32'(diff), 32'd0);
      check_eq("abort_borrow", 32'(borrow), 32'd0);
      dones = 0;
      for (int i = 0; i < 15; i++) begin
         if (done) dones++;
         @(negedge clk);
      end
      check_eq("abort_no_done", 32'(dones), 32'd0);
      run_op(8'h09, 8'h03, 1'b0);

      // Start held high: back-to-back operations.
      wait_ready();
      start  = 1'b1;
      a_in   = 8'h80;
      b_in   = 8'h01;
      bin_in = 1'b0;
      @(negedge clk);
      a_in   = 8'h7F;
      b_in   = 8'hFF;
      dones  = 0;
      c1     = 0;
      c2     = 0;
      for (int c = 1; c < 40 && dones < 2; c++) begin
         if (done) begin
            dcap[dones] = diff;
            bcap[dones] = borrow;
`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
            ocap[dones] = ovf;
`else
            ocap[dones] = 1'b0;
`endif
            if (dones == 0) c1 = c;
            else c2 = c;
            dones++;
            if (dones == 2) start = 1'b0;
         end
         @(negedge clk);
      end
      start = 1'b0;
      e1 = model(8'h80, 8'h01, 1'b0);
      e2 = model(8'h7F, 8'hFF, 1'b0);
      check_eq("b2b_dones", 32'(dones), 32'd2);
      check_eq("b2b_gap", 32'(c2 - c1), 32'd10);
      check_eq("b2b_diff1", 32'(dcap[0]), 32'(e1[7:0]));
      check_eq("b2b_borrow1", 32'(bcap[0]), 32'(e1[8]));
      check_eq("b2b_diff2", 32'(dcap[1]), 32'(e2[7:0]));
      check_eq("b2b_borrow2", 32'(bcap[1]), 32'(e2[8]));
`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
      check_eq("b2b_ovf1", 32'(ocap[0]), 32'(e1[9]));
      check_eq("b2b_ovf2", 32'(ocap[1]), 32'(e2[9]));
`endif
      repeat (3) @(negedge clk);

      // Corner operand pairs with both borrow-in values.
      ca[0] = 8'h00; ca[1] = 8'hFF; ca[2] = 8'h80; ca[3] = 8'h7F; ca[4] = 8'h01;
      for (int i = 0; i < 5; i++)
         for (int j = 0; j < 5; j++)
            for (int k = 0; k < 2; k++)
               run_op(ca[i], ca[j], k[0]);

      // Random sweep.
      for (int n = 0; n < 2500; n++)
         run_op(8'($urandom_range(255)), 8'($urandom_range(255)), 1'($urandom_range(1)));

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

   // Global time bound so a stuck DUT still ends the run.
   initial begin
      #5ms;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
